// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// default PC reset/increment values and the instruction width.
package if_stage_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] PC_INC_DEFAULT   = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } state_e;

endpackage

// File: rtl/if_stage_mux2to1.sv
// Generic 2:1 word multiplexer, used as the next-PC selector in if_stage.
module mux2to1 #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] Din0,
    input  logic [W-1:0] Din1,
    input  logic         Sel,
    output logic [W-1:0] Dout
);

    assign Dout = Sel ? Din1 : Din0;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/rdy memory
// handshake and holds the fetched word until control grants a PC update.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               PC_LdEn,
    input  logic               PC_sel,
    input  logic [INSTR_W-1:0] Immed,
    input  logic               Mem_rdy,
    input  logic [INSTR_W-1:0] Mem_data,
    output logic               Mem_req,
    output logic [INSTR_W-1:0] Mem_addr,
    output logic [INSTR_W-1:0] Instr,
    output logic               Instr_valid,
    output logic [INSTR_W-1:0] PC,
    output logic               Busy
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;

    logic [INSTR_W-1:0] seq_pc;
    logic [INSTR_W-1:0] branch_pc;
    logic [INSTR_W-1:0] next_pc;

    // Modulo-2^32 arithmetic; the shift drops Immed[31:30].
    assign seq_pc    = pc_q + PC_INC;
    assign branch_pc = seq_pc + (Immed << 2);

    mux2to1 #(
        .W (INSTR_W)
    ) u_next_pc_mux (
        .Din0 (seq_pc),
        .Din1 (branch_pc),
        .Sel  (PC_sel),
        .Dout (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ, WAIT: begin
                if (Mem_rdy) begin
                    instr_d       = Mem_data;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (PC_LdEn) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Request/busy decode straight from state so reset drops them at once.
    assign Mem_req     = (state_q == REQ) || (state_q == WAIT);
    assign Busy        = Mem_req;
    assign Mem_addr    = pc_q;
    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign Instr_valid = instr_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: table of branch/fetch vectors plus
// hand-written reset and wait-state sequences, with a fetch-data scoreboard.
module tb_if_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PC_LdEn;
    logic        PC_sel;
    logic [31:0] Immed;
    logic        Mem_rdy;
    logic [31:0] Mem_data;
    logic        Mem_req;
    logic [31:0] Mem_addr;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic [31:0] PC;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_instr;

    typedef struct {
        logic        sel;
        logic [31:0] immed;
        int          waits;
        logic [31:0] data;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[9];

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'd4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PC_LdEn     (PC_LdEn),
        .PC_sel      (PC_sel),
        .Immed       (Immed),
        .Mem_rdy     (Mem_rdy),
        .Mem_data    (Mem_data),
        .Mem_req     (Mem_req),
        .Mem_addr    (Mem_addr),
        .Instr       (Instr),
        .Instr_valid (Instr_valid),
        .PC          (PC),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Pop the oldest expected word and compare it with Instr.
    task automatic sb_check();
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got capture %h expected none", Instr);
        end else begin
            exp = sb_q.pop_front();
            chk("instr", Instr, exp);
            last_instr = exp;
        end
    endtask

    // Called in HOLD: grant a PC update and check the new fetch starts.
    task automatic branch(input logic sel, input logic [31:0] immed, input logic [31:0] exp_pc);
        PC_sel  = sel;
        Immed   = immed;
        PC_LdEn = 1'b1;
        step();
        PC_LdEn = 1'b0;
        PC_sel  = 1'($urandom);
        Immed   = $urandom;
        chk("branch_pc", PC, exp_pc);
        chk("branch_valid", 32'(Instr_valid), 32'd0);
        chk("branch_req", 32'(Mem_req), 32'd1);
        chk("branch_addr", Mem_addr, exp_pc);
        chk("branch_busy", 32'(Busy), 32'd1);
    endtask

    // Called one step after entering REQ: stall 'waits' cycles, then respond.
    task automatic fetch(input int waits, input logic [31:0] data, input logic [31:0] pc_exp);
        for (int i = 0; i < waits; i++) begin
            Mem_rdy  = 1'b0;
            Mem_data = $urandom;
            PC_LdEn  = i[0];
            PC_sel   = 1'b1;
            Immed    = $urandom;
            chk("wait_req", 32'(Mem_req), 32'd1);
            chk("wait_addr", Mem_addr, pc_exp);
            chk("wait_valid", 32'(Instr_valid), 32'd0);
            step();
            chk("wait_pc", PC, pc_exp);
        end
        PC_LdEn  = 1'b0;
        Mem_rdy  = 1'b1;
        Mem_data = data;
        sb_q.push_back(data);
        chk("resp_req", 32'(Mem_req), 32'd1);
        chk("resp_addr", Mem_addr, pc_exp);
        step();
        Mem_rdy  = 1'b0;
        chk("cap_valid", 32'(Instr_valid), 32'd1);
        if (Instr_valid === 1'b1) sb_check();
        else void'(sb_q.pop_front());
        chk("cap_req", 32'(Mem_req), 32'd0);
        chk("cap_busy", 32'(Busy), 32'd0);
        chk("cap_pc", PC, pc_exp);
    endtask

    // A stray Mem_rdy while in HOLD must not disturb anything.
    task automatic hold_check(input logic [31:0] pc_exp);
        Mem_rdy  = 1'b1;
        Mem_data = ~last_instr;
        step();
        Mem_rdy  = 1'b0;
        chk("hold_instr", Instr, last_instr);
        chk("hold_valid", 32'(Instr_valid), 32'd1);
        chk("hold_pc", PC, pc_exp);
        chk("hold_req", 32'(Mem_req), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0000, 0, 32'h1111_0001, 32'h0000_0004};
        vecs[1] = '{1'b1, 32'h0000_0002, 2, 32'h2222_0002, 32'h0000_0010};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 1, 32'h3333_0003, 32'h0000_0014};
        vecs[3] = '{1'b1, 32'h0000_003A, 5, 32'h4444_0004, 32'h0000_0100};
        vecs[4] = '{1'b1, 32'hFFFF_FFFE, 0, 32'h5555_0005, 32'h0000_00FC};
        vecs[5] = '{1'b1, 32'hFFFF_FFBF, 3, 32'h6666_0006, 32'hFFFF_FFFC};
        vecs[6] = '{1'b0, 32'h0000_0000, 0, 32'h7777_0007, 32'h0000_0000};
        vecs[7] = '{1'b1, 32'h7FFF_FFFF, 1, 32'h8888_0008, 32'h0000_0000};
        vecs[8] = '{1'b0, 32'h0000_1234, 0, 32'h9999_0009, 32'h0000_0004};

        Reset    = 1'b0;
        PC_LdEn  = 1'b0;
        PC_sel   = 1'b0;
        Immed    = '0;
        Mem_rdy  = 1'b1;
        Mem_data = 32'hDEAD_BEEF;
        last_instr = '0;
        #3 Reset = 1'b1;
        #1;
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_valid", 32'(Instr_valid), 32'd0);
        chk("rst_req", 32'(Mem_req), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        step();
        step();
        chk("rst_hold_valid", 32'(Instr_valid), 32'd0);
        Reset = 1'b0;

        // First edge after release: IDLE -> REQ, Mem_rdy ignored.
        step();
        chk("first_valid", 32'(Instr_valid), 32'd0);
        chk("first_req", 32'(Mem_req), 32'd1);
        chk("first_addr", Mem_addr, 32'h0);
        chk("first_busy", 32'(Busy), 32'd1);
        sb_q.push_back(32'hDEAD_BEEF);
        step();
        chk("first_cap_valid", 32'(Instr_valid), 32'd1);
        sb_check();
        chk("first_cap_req", 32'(Mem_req), 32'd0);
        step();
        chk("first_hold_pc", PC, 32'h0);
        chk("first_hold_instr", Instr, 32'hDEAD_BEEF);
        Mem_rdy = 1'b0;

        for (int v = 0; v < 9; v++) begin
            branch(vecs[v].sel, vecs[v].immed, vecs[v].exp_pc);
            fetch(vecs[v].waits, vecs[v].data, vecs[v].exp_pc);
            hold_check(vecs[v].exp_pc);
        end

        // Reset in the middle of a stalled fetch.
        branch(1'b0, 32'h0, 32'h0000_0008);
        Mem_rdy = 1'b0;
        step();
        step();
        chk("mid_wait_req", 32'(Mem_req), 32'd1);
        Reset = 1'b1;
        #1;
        chk("async_req", 32'(Mem_req), 32'd0);
        chk("async_busy", 32'(Busy), 32'd0);
        chk("async_valid", 32'(Instr_valid), 32'd0);
        chk("async_pc", PC, 32'h0);
        step();
        Reset    = 1'b0;
        Mem_rdy  = 1'b1;
        Mem_data = 32'h1234_5678;
        step();
        chk("late_rdy_valid", 32'(Instr_valid), 32'd0);
        chk("late_rdy_instr", Instr, 32'h0);
        chk("late_rdy_req", 32'(Mem_req), 32'd1);
        chk("late_rdy_addr", Mem_addr, 32'h0);
        fetch(0, 32'hCAFE_F00D, 32'h0);
        hold_check(32'h0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
